clmul16_kara_seq: RTL

//   Multi-cycle sequencer for a 16x16 carry-less (GF(2)[x]) polynomial multiply.

---
 rtl/clmul16_kara_seq.sv | 81 ++++++++
 1 files changed

// File: rtl/clmul16_kara_seq.sv
// clmul16_kara_seq: 16x16 carry-less multiply using a single 8x8 core over three cycles (Karatsuba split).
module clmul16_kara_seq #(
  parameter int HALF_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   in_a,
  input  logic [2*HALF_W-1:0]   in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-2:0]   out_y,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy,
  output logic [15:0]           done_cnt
);
  localparam int W  = 2*HALF_W;
  localparam int PW = 2*HALF_W-1;
  localparam int YW = 4*HALF_W-1;
  typedef enum logic [2:0] {IDLE, S_LL, S_HH, S_MM, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic [TAG_W-1:0] tag_r;
  logic [PW-1:0] p0, p2, pm;
  logic [HALF_W-1:0] ca, cb;
  // The one shared core; its operands are chosen by the state and are zero when idle or done
  always_comb begin
    ca = state == S_LL ? a_r[HALF_W-1:0] :
         state == S_HH ? a_r[W-1:HALF_W] :
         state == S_MM ? a_r[HALF_W-1:0] ^ a_r[W-1:HALF_W] : '0;
    cb = state == S_LL ? b_r[HALF_W-1:0] :
         state == S_HH ? b_r[W-1:HALF_W] :
         state == S_MM ? b_r[HALF_W-1:0] ^ b_r[W-1:HALF_W] : '0;
    pm = '0;
    for (int i = 0; i < HALF_W; i++)
      for (int j = 0; j < HALF_W; j++)
        pm[i+j] = pm[i+j] ^ (ca[i] & cb[j]);
  end
  always_comb begin
    in_ready = state == IDLE;
    busy     = state != IDLE;
    state_n  = state == IDLE ? (in_valid ? S_LL : IDLE) :
               state == S_LL ? S_HH :
               state == S_HH ? S_MM :
               state == S_MM ? DONE :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
      done_cnt  <= '0;
      a_r       <= '0;
      b_r       <= '0;
      tag_r     <= '0;
      p0        <= '0;
      p2        <= '0;
    end else begin
      state     <= state_n;
      out_valid <= state_n == DONE;
      if (state == IDLE && in_valid) begin
        a_r   <= in_a;
        b_r   <= in_b;
        tag_r <= in_tag;
      end
      if (state == S_LL) p0 <= pm;
      if (state == S_HH) p2 <= pm;
      // Middle term p0^p2^pm recovers the cross products lo*hi ^ hi*lo
      if (state == S_MM) begin
        out_y   <= YW'(p0) ^ (YW'(p0 ^ p2 ^ pm) << HALF_W) ^ (YW'(p2) << W);
        out_tag <= tag_r;
      end
      if (state == DONE && out_ready) done_cnt <= done_cnt + 16'(done_cnt != 16'hFFFF);
    end
  end
endmodule
